// File: rtl/axi_lite_master_if.sv
// Bundle of the command/response port and the five AXI-Lite channels around axi_lite_master.
// The master modport is the block's view; the slave modport is the view of whatever drives it.
interface axi_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [DATA_WIDTH-1:0] CMD_WDATA;

    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [DATA_WIDTH-1:0] RSP_RDATA;
    logic                  RSP_TIMEOUT;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RVALID;
    logic                  RREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        output CMD_READY,
        output RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
        input  RSP_READY,
        output ARADDR, ARVALID,
        input  ARREADY,
        input  RDATA, RVALID,
        output RREADY,
        output AWADDR, AWVALID,
        input  AWREADY,
        output WDATA, WVALID,
        input  WREADY,
        input  BVALID,
        output BREADY
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        input  CMD_READY,
        input  RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
        output RSP_READY,
        input  ARADDR, ARVALID,
        output ARREADY,
        output RDATA, RVALID,
        input  RREADY,
        input  AWADDR, AWVALID,
        output AWREADY,
        input  WDATA, WVALID,
        output WREADY,
        output BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one command into one read or write burst-free
// transaction, aborts on a stall longer than TIMEOUT_CYCLES, and holds the result until taken.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axi_lite_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, WRESP, DONE} state_t;

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  ar_done_q, ar_done_d;
    logic                  r_done_q, r_done_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  expire, abort;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = arvalid_q && bus.ARREADY;
    assign r_hs  = rready_q  && bus.RVALID;
    assign aw_hs = awvalid_q && bus.AWREADY;
    assign w_hs  = wvalid_q  && bus.WREADY;
    assign b_hs  = bready_q  && bus.BVALID;

    // cnt_inc is the number of bus cycles including the current one
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign expire  = (cnt_inc == CNT_MAX);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        ar_done_d     = ar_done_q;
        r_done_d      = r_done_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        abort         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.CMD_VALID) begin
                    addr_d      = bus.CMD_ADDR;
                    wdata_d     = bus.CMD_WDATA;
                    rsp_rdata_d = '0;
                    cnt_d       = '0;
                    ar_done_d   = 1'b0;
                    r_done_d    = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (bus.CMD_WRITE) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            RD: begin
                cnt_d     = cnt_inc;
                ar_done_d = ar_done_q | ar_hs;
                r_done_d  = r_done_q | r_hs;
                if (ar_hs) arvalid_d = 1'b0;
                if (r_hs && !r_done_q) rsp_rdata_d = bus.RDATA;
                if (ar_done_d && r_done_d) begin
                    state_d     = DONE;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            WR: begin
                cnt_d     = cnt_inc;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            WRESP: begin
                cnt_d = cnt_inc;
                if (b_hs) begin
                    state_d     = DONE;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                if (bus.RSP_READY) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake completing on the expiry edge took the normal exit above instead
        if (abort) begin
            state_d       = DONE;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_rdata_q   <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            ar_done_q     <= 1'b0;
            r_done_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            ar_done_q     <= ar_done_d;
            r_done_q      <= r_done_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
        end
    end

    assign bus.CMD_READY   = (state_q == IDLE);
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_RDATA   = rsp_rdata_q;
    assign bus.RSP_TIMEOUT = rsp_timeout_q;
    assign bus.ARADDR      = addr_q;
    assign bus.ARVALID     = arvalid_q;
    assign bus.RREADY      = rready_q;
    assign bus.AWADDR      = addr_q;
    assign bus.AWVALID     = awvalid_q;
    assign bus.WDATA       = wdata_q;
    assign bus.WVALID      = wvalid_q;
    assign bus.BREADY      = bready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small registered AXI-Lite slave model
// whose AW/W ready delays and AR stall can be steered per test.
module tb_axi_lite_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    // Slave model: ARREADY and RVALID rise together one cycle after ARVALID; B follows AW+W.
    logic [DW-1:0] mem [0:15];
    logic          ar_block;
    int            aw_delay, w_delay, aw_wait, w_wait;
    logic          aw_got, w_got;
    logic [3:0]    aw_idx;
    logic [DW-1:0] w_val;
    wire           s_aw_hs = bus.AWVALID && bus.AWREADY;
    wire           s_w_hs  = bus.WVALID && bus.WREADY;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b0;
            bus.RDATA   <= '0;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            aw_wait     <= 0;
            w_wait      <= 0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_idx      <= '0;
            w_val       <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[5] <= 32'hDEADBEEF;
        end else begin
            if (bus.RVALID && bus.RREADY) bus.RVALID <= 1'b0;
            if (bus.ARREADY) bus.ARREADY <= 1'b0;
            else if (bus.ARVALID && !bus.RVALID && !ar_block) begin
                bus.ARREADY <= 1'b1;
                bus.RVALID  <= 1'b1;
                bus.RDATA   <= mem[bus.ARADDR[3:0]];
            end

            if (bus.AWREADY) bus.AWREADY <= 1'b0;
            else if (bus.AWVALID) begin
                if (aw_wait >= aw_delay - 1) begin
                    bus.AWREADY <= 1'b1;
                    aw_wait     <= 0;
                end else aw_wait <= aw_wait + 1;
            end
            if (bus.WREADY) bus.WREADY <= 1'b0;
            else if (bus.WVALID) begin
                if (w_wait >= w_delay - 1) begin
                    bus.WREADY <= 1'b1;
                    w_wait     <= 0;
                end else w_wait <= w_wait + 1;
            end

            if (bus.BVALID && bus.BREADY) bus.BVALID <= 1'b0;
            if (s_aw_hs) begin aw_got <= 1'b1; aw_idx <= bus.AWADDR[3:0]; end
            if (s_w_hs)  begin w_got  <= 1'b1; w_val  <= bus.WDATA;       end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
                mem[s_aw_hs ? bus.AWADDR[3:0] : aw_idx] <= s_w_hs ? bus.WDATA : w_val;
                bus.BVALID <= 1'b1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Presents a command in IDLE; returns in cycle 1 after the accept edge.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = addr;
        bus.CMD_WDATA = data;
        step();
        bus.CMD_VALID = 1'b0;
    endtask

    // Returns the cycle (counted from the accept edge) where RSP_VALID is seen, or -1.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (bus.RSP_VALID) begin
                lat = k;
                break;
            end
            step();
        end
    endtask

    task automatic consume();
        bus.RSP_READY = 1'b1;
        step();
        bus.RSP_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            lat, n, bh;
        int            acc [0:3];
        logic          stable;
        logic [10:0]   awv, wv, br, rv;
        logic [9:0]    t_arv, t_rv;

        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.RSP_READY = 1'b0;
        ar_block = 1'b0;
        aw_delay = 1;
        w_delay  = 1;
        ARESET   = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;

        check("rst_valids", {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY,
                             bus.RSP_VALID, bus.RSP_TIMEOUT}, 64'h0);
        check("rst_buses", {bus.RSP_RDATA, bus.ARADDR}, 64'h0);
        check("rst_wbus", {bus.AWADDR, bus.WDATA}, 64'h0);
        check("rst_cmd_ready", bus.CMD_READY, 64'h1);
        @(negedge ACLK);
        ARESET = 1'b0;
        step();

        // Read of word 5
        issue(1'b0, 32'd5, '0);
        check("rd_c1_arvalid", bus.ARVALID, 64'h1);
        check("rd_c1_araddr", bus.ARADDR, 64'd5);
        check("rd_c1_cmd_ready", bus.CMD_READY, 64'h0);
        step();
        check("rd_c2_arvalid", {bus.ARVALID, bus.RSP_VALID}, 64'b10);
        step();
        check("rd_c3_rsp", {bus.ARVALID, bus.RREADY, bus.RSP_VALID, bus.RSP_TIMEOUT}, 64'b0010);
        check("rd_c3_rdata", bus.RSP_RDATA, 64'hDEADBEEF);
        consume();
        check("rd_idle", {bus.CMD_READY, bus.RSP_VALID}, 64'b10);

        // Write word 7 then read it back
        issue(1'b1, 32'd7, 32'h12345678);
        check("wr_c1_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 64'b110);
        check("wr_c1_addr_data", {bus.AWADDR, bus.WDATA}, {32'd7, 32'h12345678});
        wait_rsp(lat);
        check("wr_latency", lat, 64'd4);
        check("wr_rdata_zero", {bus.RSP_RDATA, 31'd0, bus.RSP_TIMEOUT}, 64'h0);
        consume();
        issue(1'b0, 32'd7, '0);
        wait_rsp(lat);
        check("rb_latency", lat, 64'd3);
        check("rb_rdata", bus.RSP_RDATA, 64'h12345678);

        // Backpressure with another command waiting
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 32'd5;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!(bus.RSP_VALID === 1'b1 && bus.RSP_RDATA === 32'h12345678 && bus.CMD_READY === 1'b0))
                stable = 1'b0;
        end
        check("bp_stable", stable, 64'h1);
        consume();
        bus.CMD_VALID = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.RSP_VALID) n++;
        end
        check("bp_single_rsp", n, 64'd0);
        check("bp_cmd_ready", bus.CMD_READY, 64'h1);

        // Back-to-back reads with RSP_READY held high
        bus.RSP_READY = 1'b1;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 32'd5;
        n = 0;
        for (int i = 0; i <= 8; i++) begin
            if (bus.CMD_READY && n < 4) begin
                acc[n] = i;
                n++;
            end
            step();
        end
        bus.CMD_VALID = 1'b0;
        wait_rsp(lat);
        check("b2b_last_lat", lat, 64'd3);
        check("b2b_last_rdata", bus.RSP_RDATA, 64'hDEADBEEF);
        step();
        bus.RSP_READY = 1'b0;
        check("b2b_accepts", n, 64'd3);
        check("b2b_spacing", {acc[1] - acc[0], acc[2] - acc[1]}, {32'd4, 32'd4});

        // AWREADY after 1 cycle, WREADY after 5
        aw_delay = 1;
        w_delay  = 5;
        issue(1'b1, 32'd9, 32'hA5A5A5A5);
        awv = '0; wv = '0; br = '0; rv = '0; bh = 0;
        for (int k = 1; k <= 10; k++) begin
            awv[k] = bus.AWVALID;
            wv[k]  = bus.WVALID;
            br[k]  = bus.BREADY;
            rv[k]  = bus.RSP_VALID;
            if (bus.BVALID && bus.BREADY) bh++;
            step();
        end
        check("split_awvalid", awv, 64'h006);
        check("split_wvalid", wv, 64'h07E);
        check("split_bready", br, 64'h080);
        check("split_rsp_valid", rv, 64'h700);
        check("split_b_handshakes", bh, 64'd1);
        consume();
        w_delay = 1;
        issue(1'b0, 32'd9, '0);
        wait_rsp(lat);
        check("split_readback", bus.RSP_RDATA, 64'hA5A5A5A5);
        consume();

        // AR stalled forever: abort after TO bus cycles
        ar_block = 1'b1;
        issue(1'b0, 32'd5, '0);
        t_arv = '0;
        t_rv  = '0;
        for (int k = 1; k <= 9; k++) begin
            t_arv[k] = bus.ARVALID;
            t_rv[k]  = bus.RSP_VALID;
            if (k < 9) step();
        end
        check("to_arvalid", t_arv, 64'h1FE);
        check("to_rsp_valid", t_rv, 64'h200);
        check("to_flags", {bus.RSP_TIMEOUT, bus.RREADY}, 64'b10);
        check("to_rdata", bus.RSP_RDATA, 64'h0);
        ar_block = 1'b0;
        consume();
        check("to_cleared", {bus.RSP_TIMEOUT, bus.CMD_READY}, 64'b01);
        issue(1'b0, 32'd5, '0);
        wait_rsp(lat);
        check("to_next_lat", lat, 64'd3);
        check("to_next_rsp", {bus.RSP_RDATA, 31'd0, bus.RSP_TIMEOUT}, {32'hDEADBEEF, 32'd0});
        consume();

        // Reset in cycle 2 of a write
        issue(1'b1, 32'd3, 32'h11112222);
        step();
        #2;
        ARESET = 1'b1;
        #1;
        check("mid_rst_valids", {bus.ARVALID, bus.AWVALID, bus.WVALID, bus.BREADY, bus.RSP_VALID}, 64'h0);
        check("mid_rst_cmd_ready", bus.CMD_READY, 64'h1);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.RSP_VALID) n++;
        end
        check("mid_rst_no_rsp", n, 64'd0);
        check("mid_rst_ready_after", bus.CMD_READY, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
